// File: rtl/cpu_params_pkg.sv
// rtl/cpu_params_pkg.sv - shared CPU sizing and the GPR write-port record
package cpu_params_pkg;
  localparam int MAX_GPR        = 32;
  localparam int RSZ            = 32;
  localparam int GPR_AW         = $clog2(MAX_GPR);
  localparam int LL_DEPTH_DEF   = 2;
  localparam int STARVE_MAX_DEF = 4;

  typedef struct packed {
    logic [GPR_AW-1:0] addr;
    logic [RSZ-1:0]    data;
  } gpr_wr_t;
endpackage

// File: rtl/gpr_wr_fifo.sv
// rtl/gpr_wr_fifo.sv - synchronous FIFO of pending long-latency GPR writes
module gpr_wr_fifo
  import cpu_params_pkg::*;
#(
  parameter int DEPTH = LL_DEPTH_DEF
) (
  input  logic    clk_in,
  input  logic    reset_in,
  input  logic    push,
  input  logic    pop,
  input  gpr_wr_t din,
  output logic    full,
  output logic    empty,
  output gpr_wr_t head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  gpr_wr_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Wrap modulo DEPTH so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (do_pop)
        rd_ptr <= wrap_inc(rd_ptr);
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/gpr_wr_arb.sv
// rtl/gpr_wr_arb.sv - merges WB and long-latency results onto the single GPR write port
module gpr_wr_arb
  import cpu_params_pkg::*;
#(
  parameter int LL_DEPTH   = LL_DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [GPR_AW-1:0] wb_addr,
  input  logic [RSZ-1:0]    wb_data,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [GPR_AW-1:0] ll_addr,
  input  logic [RSZ-1:0]    ll_data,
  input  logic              ll_issue,
  input  logic [GPR_AW-1:0] ll_issue_addr,
  output logic [MAX_GPR-1:0] pend,
  output logic              sb_err,
  output logic              Rd_wr,
  output logic [GPR_AW-1:0] Rd_addr,
  output logic [RSZ-1:0]    Rd_data
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  gpr_wr_t      head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_nonempty;
  logic         force_ll;
  logic         gnt_ll;
  logic         gnt_wb;
  logic [SW-1:0] starve_cnt;
  logic [MAX_GPR-1:0] set_vec;
  logic [MAX_GPR-1:0] clr_vec;
  logic [MAX_GPR-1:0] pend_nxt;
  logic         issue_hit;
  logic         ll_orphan;

  gpr_wr_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .push     (ll_valid & ll_ready),
    .pop      (gnt_ll),
    .din      ('{addr: ll_addr, data: ll_data}),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign fifo_nonempty = ~fifo_empty;
  assign ll_ready      = ~fifo_full;
  assign force_ll      = fifo_nonempty & (starve_cnt == SW'(STARVE_MAX));
  assign wb_ready      = ~force_ll;
  assign gnt_ll        = fifo_nonempty & (force_ll | ~wb_valid);
  assign gnt_wb        = wb_valid & ~force_ll;

  // x0 entries are consumed without touching the scoreboard.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (ll_issue && ll_issue_addr != '0)
      set_vec[ll_issue_addr] = 1'b1;
    if (gnt_ll && head.addr != '0)
      clr_vec[head.addr] = 1'b1;
    pend_nxt    = (pend & ~clr_vec) | set_vec;
    pend_nxt[0] = 1'b0;
  end

  assign issue_hit = ll_issue && (ll_issue_addr != '0) && pend[ll_issue_addr]
                     && !clr_vec[ll_issue_addr];
  assign ll_orphan = gnt_ll && (head.addr != '0) && !pend[head.addr];

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      starve_cnt <= '0;
      pend       <= '0;
      sb_err     <= 1'b0;
      Rd_wr      <= 1'b0;
      Rd_addr    <= '0;
      Rd_data    <= '0;
    end else begin
      if (!fifo_nonempty || gnt_ll)
        starve_cnt <= '0;
      else if (gnt_wb && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;

      pend   <= pend_nxt;
      sb_err <= sb_err | issue_hit | ll_orphan;

      Rd_wr <= 1'b0;
      if (gnt_ll) begin
        Rd_wr   <= (head.addr != '0);
        Rd_addr <= head.addr;
        Rd_data <= head.data;
      end else if (gnt_wb) begin
        Rd_wr   <= (wb_addr != '0);
        Rd_addr <= wb_addr;
        Rd_data <= wb_data;
      end
    end
  end
endmodule

// File: tb/tb_gpr_wr_arb.sv
// tb/tb_gpr_wr_arb.sv - scoreboard bench for the GPR write-port arbiter
module tb_gpr_wr_arb;
  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ll_valid, ll_ready;
  logic [4:0]  ll_addr;
  logic [31:0] ll_data;
  logic        ll_issue;
  logic [4:0]  ll_issue_addr;
  logic [31:0] pend;
  logic        sb_err;
  logic        Rd_wr;
  logic [4:0]  Rd_addr;
  logic [31:0] Rd_data;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  gpr_wr_arb dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
    .ll_issue(ll_issue), .ll_issue_addr(ll_issue_addr),
    .pend(pend), .sb_err(sb_err),
    .Rd_wr(Rd_wr), .Rd_addr(Rd_addr), .Rd_data(Rd_data)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, in the expected cycle.
  always @(negedge clk_in) begin
    if (Rd_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none (cycle %0d)",
                 Rd_addr, Rd_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(Rd_addr), 64'(e.addr));
        chk("wr_data", 64'(Rd_data), 64'(e.data));
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Expected write observed dly cycles after the current one.
  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int dly);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = cyc + dly;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    ll_valid = 0; ll_addr = 0; ll_data = 0;
    ll_issue = 0; ll_issue_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_in = 1;
    tick();
    reset_in = 0;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    chk("rst_rd_wr", 64'(Rd_wr), 0);
    chk("rst_rd_addr", 64'(Rd_addr), 0);
    chk("rst_rd_data", 64'(Rd_data), 0);
    chk("rst_pend", 64'(pend), 0);
    chk("rst_sb_err", 64'(sb_err), 0);
    chk("rst_ll_ready", 64'(ll_ready), 1);
    chk("rst_wb_ready", 64'(wb_ready), 1);

    // WB only
    wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    chk("wbonly_ready", 64'(wb_ready), 1);
    expect_wr(5, 32'hDEADBEEF, 1);
    tick();
    idle_inputs();
    tick();

    // LL fill/drain under continuous WB pressure
    do_reset();
    ll_issue = 1; ll_issue_addr = 7; tick();
    ll_issue_addr = 9; tick();
    ll_issue = 0;
    chk("fill_pend", 64'(pend), 64'h280);
    for (int i = 0; i < 11; i++) begin
      wb_valid = 1; wb_addr = 1; wb_data = 32'h100 + i;
      ll_valid = (i < 2);
      ll_addr  = (i == 0) ? 5'd7 : 5'd9;
      ll_data  = (i == 0) ? 32'h700 : 32'h900;
      chk($sformatf("fill_wb_ready_%0d", i), 64'(wb_ready), (i == 5 || i == 10) ? 0 : 1);
      if (i == 2) chk("fill_ll_full", 64'(ll_ready), 0);
      if (i == 5)       expect_wr(7, 32'h700, 1);
      else if (i == 10) expect_wr(9, 32'h900, 1);
      else              expect_wr(1, 32'h100 + i, 1);
      tick();
    end
    idle_inputs();
    tick();
    chk("fill_pend_clear", 64'(pend), 0);
    chk("fill_sb_err", 64'(sb_err), 0);

    // Idle slot
    do_reset();
    ll_issue = 1; ll_issue_addr = 3; tick();
    ll_issue = 0;
    chk("idle_pend_set", 64'(pend), 64'h8);
    ll_valid = 1; ll_addr = 3; ll_data = 32'h33;
    expect_wr(3, 32'h33, 2);
    tick();
    ll_valid = 0;
    chk("idle_pend_held", 64'(pend), 64'h8);
    tick();
    chk("idle_pend_clr", 64'(pend), 0);
    chk("idle_sb_err", 64'(sb_err), 0);

    // x0 handling
    do_reset();
    ll_issue = 1; ll_issue_addr = 6; tick();
    ll_issue = 0;
    wb_valid = 1; wb_addr = 0; wb_data = 32'h1234;
    ll_valid = 1; ll_addr = 0; ll_data = 32'h5678;
    chk("x0_wb_ready", 64'(wb_ready), 1);
    chk("x0_ll_ready", 64'(ll_ready), 1);
    tick();
    idle_inputs();
    chk("x0_rd_wr_a", 64'(Rd_wr), 0);
    tick();
    chk("x0_rd_wr_b", 64'(Rd_wr), 0);
    tick();
    chk("x0_rd_wr_c", 64'(Rd_wr), 0);
    chk("x0_pend", 64'(pend), 64'h40);
    chk("x0_sb_err", 64'(sb_err), 0);
    chk("x0_ll_ready_after", 64'(ll_ready), 1);

    // Scoreboard: double issue
    do_reset();
    ll_issue = 1; ll_issue_addr = 4; tick();
    tick();
    ll_issue = 0;
    chk("sb_double_issue", 64'(sb_err), 1);

    // Scoreboard: reissue in the cycle the LL write is granted
    do_reset();
    ll_issue = 1; ll_issue_addr = 4; tick();
    ll_issue = 0;
    ll_valid = 1; ll_addr = 4; ll_data = 32'h44;
    tick();
    ll_valid = 0;
    ll_issue = 1; ll_issue_addr = 4;
    expect_wr(4, 32'h44, 1);
    tick();
    ll_issue = 0;
    chk("sb_set_wins_pend", 64'(pend), 64'h10);
    chk("sb_set_wins_err", 64'(sb_err), 0);

    // Reset mid-operation
    do_reset();
    ll_issue = 1; ll_issue_addr = 4;
    ll_valid = 1; ll_addr = 4; ll_data = 32'hAA;
    wb_valid = 1; wb_addr = 2; wb_data = 32'hA;
    expect_wr(2, 32'hA, 1);
    tick();
    ll_issue = 0;
    ll_data = 32'hBB;
    wb_data = 32'hB;
    expect_wr(2, 32'hB, 1);
    tick();
    ll_valid = 0;
    chk("midrst_full", 64'(ll_ready), 0);
    chk("midrst_pend_before", 64'(pend), 64'h10);
    idle_inputs();
    reset_in = 1;
    tick();
    reset_in = 0;
    chk("midrst_pend", 64'(pend), 0);
    chk("midrst_ll_ready", 64'(ll_ready), 1);
    chk("midrst_rd_wr", 64'(Rd_wr), 0);
    repeat (8) tick();

    chk("exp_q_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
